// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light: phase codes and per-phase durations.
package traffic_pkg;

  // Phase codes consumed by the light decoder and the VGA display.
  localparam logic [1:0] PH_G1 = 2'b00;  // road1 green, road2 red
  localparam logic [1:0] PH_Y1 = 2'b01;  // road1 yellow, road2 red
  localparam logic [1:0] PH_G2 = 2'b10;  // road1 red, road2 green
  localparam logic [1:0] PH_Y2 = 2'b11;  // road1 red, road2 yellow

  typedef enum logic [1:0] {
    StG1 = PH_G1,
    StY1 = PH_Y1,
    StG2 = PH_G2,
    StY2 = PH_Y2
  } phase_e;

  // Fixed rotation 00 -> 01 -> 10 -> 11 -> 00.
  function automatic phase_e next_phase(input phase_e ph);
    case (ph)
      StG1:    next_phase = StY1;
      StY1:    next_phase = StG2;
      StG2:    next_phase = StY2;
      default: next_phase = StG1;
    endcase
  endfunction

  // Duration in ticks of the given phase.
  function automatic int unsigned phase_dur(input logic [1:0] ph, input int unsigned g1,
                                            input int unsigned y1, input int unsigned g2,
                                            input int unsigned y2);
    case (ph)
      PH_G1:   phase_dur = g1;
      PH_Y1:   phase_dur = y1;
      PH_G2:   phase_dur = g2;
      default: phase_dur = y2;
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Clock-enable prescaler: one-cycle tick every CLK_DIV cycles while not cleared.
module tick_gen #(
  parameter int unsigned CLK_DIV = 50000000
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] MaxCnt = CW'(CLK_DIV - 1);

  if (CLK_DIV < 1) begin : g_div_check
    $error("tick_gen: CLK_DIV must be >= 1");
  end

  logic [CW-1:0] cnt_q, cnt_d;

  // Gated so no stray tick leaks out while the sequencer is held.
  assign tick = !clr && (cnt_q == MaxCnt);

  // Next prescaler value: clear, wrap on the tick cycle, else count up.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || cnt_q == MaxCnt) begin
      cnt_d = '0;
    end
  end

  // Prescaler register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/traffic_phase_seq.sv
// Timed phase sequencer for the two-road traffic light with a per-phase countdown.
module traffic_phase_seq
  import traffic_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50000000,
  parameter int unsigned T_G1    = 25,
  parameter int unsigned T_Y1    = 5,
  parameter int unsigned T_G2    = 20,
  parameter int unsigned T_Y2    = 5,
  parameter int unsigned CNT_W   = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SW1,
  output logic [1:0]       EN_out,
  output logic [CNT_W-1:0] remain,
  output logic             phase_done
);

  localparam int unsigned DurMax = (1 << CNT_W) - 1;
  localparam logic [CNT_W-1:0] LoadG1 = CNT_W'(T_G1);

  if (T_G1 < 1 || T_G1 > DurMax || T_Y1 < 1 || T_Y1 > DurMax ||
      T_G2 < 1 || T_G2 > DurMax || T_Y2 < 1 || T_Y2 > DurMax) begin : g_dur_check
    $error("traffic_phase_seq: every phase duration must lie in 1..2**CNT_W-1");
  end

  logic             tick;
  logic             clr;
  phase_e           state_q, state_d, state_nx;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic             done_q, done_d;

  assign clr = ~SW1;

  tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_gen (
    .CLK (CLK),
    .RST (RST),
    .clr (clr),
    .tick(tick)
  );

  // Next phase/countdown: hold when idle, count down on tick, advance on the last tick.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    done_d   = 1'b0;
    state_nx = next_phase(state_q);
    if (!SW1) begin
      state_d  = StG1;
      remain_d = LoadG1;
    end else if (tick) begin
      if (remain_q == CNT_W'(1)) begin
        state_d  = state_nx;
        remain_d = CNT_W'(phase_dur(state_nx, T_G1, T_Y1, T_G2, T_Y2));
        done_d   = 1'b1;
      end else begin
        remain_d = remain_q - CNT_W'(1);
      end
    end
  end

  // State, countdown and pulse registers; reset wins over SW1.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= StG1;
      remain_q <= LoadG1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      done_q   <= done_d;
    end
  end

  assign EN_out     = state_q;
  assign remain     = remain_q;
  assign phase_done = done_q;

endmodule

// File: tb/tb_traffic_phase_seq.sv
// Bench for traffic_phase_seq: four configurations checked every cycle against a
// timeline model (elapsed run cycles -> ticks -> position within the phase cycle).
module tb_traffic_phase_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rst_n;
  logic [3:0] sw1;
  logic [1:0] en   [4];
  logic [5:0] rem  [4];
  logic       done [4];

  int checks   = 0;
  int failures = 0;

  // Per-instance configuration: clock divider and durations G1, Y1, G2, Y2.
  int div_t [4] = '{4, 4, 1, 8};
  int dur_t [4][4] = '{'{25, 5, 20, 5}, '{3, 1, 2, 1}, '{1, 1, 1, 1}, '{3, 1, 2, 1}};
  // Run edges seen since the last reset or SW1-low edge.
  int cyc_n [4];
  int hold  [4];

  traffic_phase_seq #(.CLK_DIV(4)) dut_a (
    .CLK(clk), .RST(rst_n[0]), .SW1(sw1[0]),
    .EN_out(en[0]), .remain(rem[0]), .phase_done(done[0])
  );
  traffic_phase_seq #(.CLK_DIV(4), .T_G1(3), .T_Y1(1), .T_G2(2), .T_Y2(1)) dut_b (
    .CLK(clk), .RST(rst_n[1]), .SW1(sw1[1]),
    .EN_out(en[1]), .remain(rem[1]), .phase_done(done[1])
  );
  traffic_phase_seq #(.CLK_DIV(1), .T_G1(1), .T_Y1(1), .T_G2(1), .T_Y2(1)) dut_c (
    .CLK(clk), .RST(rst_n[2]), .SW1(sw1[2]),
    .EN_out(en[2]), .remain(rem[2]), .phase_done(done[2])
  );
  traffic_phase_seq #(.CLK_DIV(8), .T_G1(3), .T_Y1(1), .T_G2(2), .T_Y2(1)) dut_d (
    .CLK(clk), .RST(rst_n[3]), .SW1(sw1[3]),
    .EN_out(en[3]), .remain(rem[3]), .phase_done(done[3])
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs from elapsed run cycles: ticks so far, folded into one phase cycle.
  function automatic void ref_out(input int i, output int ph, output int rm, output int dn);
    int ticks, total, t, start;
    ticks = cyc_n[i] / div_t[i];
    total = dur_t[i][0] + dur_t[i][1] + dur_t[i][2] + dur_t[i][3];
    t     = ticks % total;
    start = 0;
    ph = 0; rm = 0; dn = 0;
    for (int p = 0; p < 4; p++) begin
      if (t >= start && t < start + dur_t[i][p]) begin
        ph = p;
        rm = start + dur_t[i][p] - t;
        dn = (cyc_n[i] > 0 && (cyc_n[i] % div_t[i]) == 0 && t == start) ? 1 : 0;
      end
      start += dur_t[i][p];
    end
  endfunction

  // One clock edge: advance the model with the applied inputs, then compare all instances.
  task automatic step();
    int ph, rm, dn;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (!rst_n[i] || !sw1[i]) cyc_n[i] = 0;
      else cyc_n[i]++;
    end
    #1;
    for (int i = 0; i < 4; i++) begin
      ref_out(i, ph, rm, dn);
      check($sformatf("en[%0d]", i), int'(en[i]), ph);
      check($sformatf("remain[%0d]", i), int'(rem[i]), rm);
      check($sformatf("phase_done[%0d]", i), int'(done[i]), dn);
    end
  endtask

  initial begin
    int ph, rm, dn, pulses;
    bit found;
    rst_n = 4'h0;
    sw1   = 4'hF;
    for (int i = 0; i < 4; i++) begin
      cyc_n[i] = 0;
      hold[i]  = 0;
    end

    // Reset held for three edges.
    repeat (3) step();
    check("reset_en", int'(en[0]), 0);
    check("reset_remain", int'(rem[0]), 25);
    check("reset_done", int'(done[0]), 0);

    // Release; first decrement on the 4th edge, full 28-cycle loop on dut_b.
    rst_n  = 4'hF;
    pulses = 0;
    for (int k = 1; k <= 28; k++) begin
      step();
      if (done[1]) pulses++;
      if (k == 3) check("pre_first_dec", int'(rem[0]), 25);
      if (k == 4) check("first_dec", int'(rem[0]), 24);
    end
    check("cycle_pulses", pulses, 4);
    check("cycle_wrap_en", int'(en[1]), 0);
    check("cycle_wrap_remain", int'(rem[1]), 3);

    // SW1 dropped in phase 10 with remain 1.
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      ref_out(1, ph, rm, dn);
      if (ph == 2 && rm == 1) found = 1;
      else step();
    end
    check("find_g2_last", int'(found), 1);
    sw1[1] = 1'b0;
    step();
    check("sw1_hold_en", int'(en[1]), 0);
    check("sw1_hold_remain", int'(rem[1]), 3);
    check("sw1_hold_done", int'(done[1]), 0);
    sw1[1] = 1'b1;
    repeat (3) step();
    check("sw1_resume_wait", int'(rem[1]), 3);
    step();
    check("sw1_resume_tick", int'(rem[1]), 2);

    // Reset on the very cycle that would wrap 11 -> 00.
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      ref_out(1, ph, rm, dn);
      if (ph == 3 && rm == 1 && (cyc_n[1] % 4) == 3) found = 1;
      else step();
    end
    check("find_y2_tick", int'(found), 1);
    rst_n[1] = 1'b0;
    step();
    check("rst_tick_en", int'(en[1]), 0);
    check("rst_tick_remain", int'(rem[1]), 3);
    check("rst_tick_done", int'(done[1]), 0);
    rst_n[1] = 1'b1;

    // Random resets and SW1 drops on every instance, checked each cycle.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (hold[i] > 0) begin
          hold[i]--;
          if (hold[i] == 0) begin
            rst_n[i] = 1'b1;
            sw1[i]   = 1'b1;
          end
        end else begin
          case ($urandom_range(99, 0))
            0: begin rst_n[i] = 1'b0; hold[i] = $urandom_range(3, 1); end
            1: begin sw1[i] = 1'b0; hold[i] = $urandom_range(6, 1); end
            2: begin rst_n[i] = 1'b0; sw1[i] = 1'b0; hold[i] = $urandom_range(2, 1); end
            default: ;
          endcase
        end
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_phase_seq.md
Name: traffic_phase_seq

Overview:
- Timed phase sequencer for the two-road traffic light.
- Produces the 2-bit phase code EN_out that the light decoder consumes, plus the remaining seconds of the current phase for the VGA countdown display.
- Contains its own clock-enable prescaler, so all phase timing is counted in ticks derived from CLK.

Parameters:
- CLK_DIV, 50000000, CLK cycles per tick (one tick = 1 s at 50 MHz); must be >= 1.
- T_G1, 25, ticks in phase 00 (road1 green, road2 red).
- T_Y1, 5, ticks in phase 01 (road1 yellow, road2 red).
- T_G2, 20, ticks in phase 10 (road1 red, road2 green).
- T_Y2, 5, ticks in phase 11 (road1 red, road2 yellow).
- CNT_W, 6, width of the remaining-time counter. Every T_* must be >= 1 and <= 2^CNT_W-1; violation is an elaboration error.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST  input  1  synchronous reset, active-low.
- SW1  input  1  run enable; 0 = hold the sequencer at its initial state.
- EN_out  output  2  current phase code, registered.
- remain  output  CNT_W  ticks left in the current phase (T..1), registered.
- phase_done  output  1  one-CLK pulse on every phase change.

Behaviour:
- Reset (RST==0 at a CLK edge):
  - EN_out=2'b00, remain=T_G1, phase_done=0, prescaler=0.
  - RST has priority over SW1.
- SW1==0 (with RST==1): same register values as reset, applied synchronously every cycle. When SW1 rises, sequencing resumes from phase 00 with the full T_G1.
- Prescaler:
  - Counts 0..CLK_DIV-1 while running.
  - tick=1 for the single cycle in which prescaler==CLK_DIV-1; the prescaler then wraps to 0.
  - The first tick occurs CLK_DIV cycles after reset release or SW1 rise.
  - CLK_DIV=1 gives tick every cycle.
- Phase FSM, states = EN_out encodings. Order is 00 -> 01 -> 10 -> 11 -> 00, with no other transitions.
- On a tick edge:
  - If remain==1: advance to the next phase, load remain with that phase's T_*, and set phase_done=1 for that one cycle.
  - Otherwise: remain decrements by 1.
- Without a tick: state and remain hold, and phase_done=0.
- Each phase therefore lasts exactly T_* ticks, and remain shows T_*..1. remain never reads 0 after reset.
- EN_out and remain change on the same CLK edge (the edge that samples tick), with no combinational path from inputs to outputs.
- A duration of 1 means the phase lasts a single tick: remain=1 on entry, and the next tick advances.
- Reset or SW1 low during any phase aborts it immediately (next edge) with no phase_done pulse.
- Full cycle length = T_G1+T_Y1+T_G2+T_Y2 ticks. Wrap from 11 back to 00 is an ordinary transition that pulses phase_done.

Decomposition:
- Shared package traffic_pkg holds:
  - Phase code constants PH_G1=2'b00, PH_Y1=2'b01, PH_G2=2'b10, PH_Y2=2'b11. These are shared with the light decoder and the VGA display.
  - A duration-lookup function mapping phase code to T_*.
- One sub-module, tick_gen (parameter CLK_DIV; ports CLK, RST, clr, tick), implements the prescaler. clr is driven by !SW1.
- The FSM and remain counter stay in traffic_phase_seq.

Test Plan:
- Reset: hold RST=0 for 3 cycles with SW1=1 -> EN_out=00, remain=25, phase_done=0. Release; with CLK_DIV=4 the first decrement (remain=24) appears at the 4th edge after release.
- Full cycle (CLK_DIV=4, T_G1=3, T_Y1=1, T_G2=2, T_Y2=1): remain sequence 3,2,1 | 1 | 2,1 | 1, then back to 3. EN_out goes 00,01,10,11,00. Check:
  - phase_done pulses exactly 4 times, each 1 cycle wide.
  - 7 ticks = 28 CLK cycles per cycle.
- SW1 hold: drop SW1 during phase 10 with remain=1 -> next edge gives EN_out=00, remain=T_G1, no phase_done. Raise SW1 -> the first tick arrives CLK_DIV cycles later.
- Mid-operation reset: assert RST=0 on the exact cycle tick=1 with remain==1 in phase 11 -> reset wins (EN_out=00, remain=T_G1, phase_done=0).
- CLK_DIV=1 with all T_*=1: EN_out advances every CLK cycle (00,01,10,11,00,...), remain is constant at 1, and phase_done is high continuously.
- Hold without tick: freeze the prescaler via a CLK_DIV=8 run and sample between ticks -> EN_out and remain remain stable for 7 cycles between ticks.
